fsm_ctx_scheduler: RTL and testbench

Time-multiplexes a single 4-state "run of ones" detector across `N_CH` serial bit channels. Each channel keeps its own 2-bit state context. A round-robin arbiter picks one pending bit per cycle and runs it through the shared next-state logic. A registered hit event reports which channel just completed a run of two consecutive ones. The block sits between the per-channel bit sources and the event collector, and replaces N copies of the standalone detector.

---
 rtl/fsm_ctx_pkg.sv | 36 +++
 rtl/ctx_rr_arb.sv | 55 +++++
 rtl/fsm_ctx_scheduler.sv | 89 ++++++++
 tb/tb_fsm_ctx_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_ctx_pkg.sv
// ============================================================================
// fsm_ctx_pkg : context states and shared next-state/hit functions
// Rev 1.0
// ============================================================================
`default_nettype none

package fsm_ctx_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } ctx_state_t;

  function automatic ctx_state_t ctx_next(ctx_state_t s, logic b);
    ctx_state_t n;
    n = S0;
    if (b) begin
      case (s)
        S0:      n = S1;
        S1:      n = S2;
        default: n = S3;
      endcase
    end
    return n;
  endfunction

  // Entry into S2 is only possible from S1, so this marks the second 1 of a run.
  function automatic logic ctx_is_hit(ctx_state_t s, logic b);
    return (s == S1) && b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctx_rr_arb.sv
// ============================================================================
// ctx_rr_arb : round-robin arbiter, one-hot + binary grant, owns rr pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module ctx_rr_arb
  import fsm_ctx_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            adv,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx
);

  logic [CH_W-1:0] r_ptr;
  logic            w_found;

  // First pass covers [ptr, N_CH-1], second pass the wrapped part [0, ptr-1].
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && req[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = CH_W'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && req[i]) begin
        w_found = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (adv) begin
      r_ptr <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fsm_ctx_scheduler.sv
// ============================================================================
// fsm_ctx_scheduler : one shared run-of-ones detector time-multiplexed over
//                     N_CH channel contexts with a registered hit event
// Rev 1.0
// ============================================================================
`default_nettype none

module fsm_ctx_scheduler
  import fsm_ctx_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   bit_valid,
  input  logic [N_CH-1:0]   bit_data,
  output logic [N_CH-1:0]   bit_ready,
  input  logic [N_CH-1:0]   ch_clear,
  output logic              hit_valid,
  output logic [CH_W-1:0]   hit_ch,
  output logic [2*N_CH-1:0] ch_state
);

  ctx_state_t      r_ctx [N_CH];
  logic            r_hit_valid;
  logic [CH_W-1:0] r_hit_ch;

  logic [N_CH-1:0] w_cand;
  logic [N_CH-1:0] w_gnt;
  logic [CH_W-1:0] w_idx;
  logic            w_fire;
  ctx_state_t      w_cur;
  ctx_state_t      w_next;
  logic            w_hit;

  // A clearing channel is held off so its pending bit survives the clear.
  assign w_cand = bit_valid & ~ch_clear;

  ctx_rr_arb #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_cand),
    .adv     (w_fire),
    .gnt     (w_gnt),
    .gnt_idx (w_idx)
  );

  assign bit_ready = w_gnt;
  assign w_fire    = |w_gnt;
  assign w_cur     = r_ctx[w_idx];
  assign w_next    = ctx_next(w_cur, bit_data[w_idx]);
  assign w_hit     = w_fire && ctx_is_hit(w_cur, bit_data[w_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_ctx[i] <= S0;
      end
      r_hit_valid <= 1'b0;
      r_hit_ch    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_clear[i]) begin
          r_ctx[i] <= S0;
        end else if (w_gnt[i]) begin
          r_ctx[i] <= w_next;
        end
      end
      r_hit_valid <= w_hit;
      if (w_hit) begin
        r_hit_ch <= w_idx;
      end
    end
  end

  assign hit_valid = r_hit_valid;
  assign hit_ch    = r_hit_ch;

  for (genvar g = 0; g < N_CH; g++) begin : g_state
    assign ch_state[2*g +: 2] = r_ctx[g];
  end

endmodule

`default_nettype wire

// File: tb/tb_fsm_ctx_scheduler.sv
// ============================================================================
// tb_fsm_ctx_scheduler : scoreboard bench for fsm_ctx_scheduler (N_CH=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fsm_ctx_scheduler;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] bit_valid;
  logic [N_CH-1:0] bit_data;
  logic [N_CH-1:0] bit_ready;
  logic [N_CH-1:0] ch_clear;
  logic            hit_valid;
  logic [CH_W-1:0] hit_ch;
  logic [2*N_CH-1:0] ch_state;

  fsm_ctx_scheduler #(.N_CH(N_CH), .CH_W(CH_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .bit_ready (bit_ready),
    .ch_clear  (ch_clear),
    .hit_valid (hit_valid),
    .hit_ch    (hit_ch),
    .ch_state  (ch_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       hv;
    logic [1:0] ch;
    logic [7:0] st;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  int m_ctx [N_CH];
  int m_ptr;
  int m_hch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_ctx[i] = 0;
    m_ptr = 0;
    m_hch = 0;
    sb_q.delete();
  endtask

  function automatic logic [7:0] model_pack();
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < N_CH; i++) p[2*i +: 2] = m_ctx[i][1:0];
    return p;
  endfunction

  // Called just after a rising edge; drives one cycle, scores it after the next edge.
  task automatic cycle(input logic [3:0] v, input logic [3:0] d, input logic [3:0] c);
    logic [3:0] cand;
    logic [3:0] egnt;
    int         g;
    int         nxt;
    exp_t       e;
    exp_t       got;
    bit_valid = v;
    bit_data  = d;
    ch_clear  = c;
    cand = v & ~c;
    egnt = '0;
    g    = -1;
    for (int k = 0; k < N_CH; k++) begin
      int j;
      j = (m_ptr + k) % N_CH;
      if (g < 0 && cand[j]) g = j;
    end
    if (g >= 0) egnt[g] = 1'b1;
    #1;
    chk("bit_ready", 32'(bit_ready), 32'(egnt));
    e.hv = 1'b0;
    if (g >= 0) begin
      nxt = d[g] ? ((m_ctx[g] == 3) ? 3 : m_ctx[g] + 1) : 0;
      if (nxt == 2 && m_ctx[g] != 2) begin
        e.hv  = 1'b1;
        m_hch = g;
      end
      m_ctx[g] = nxt;
      m_ptr = (g + 1) % N_CH;
    end
    for (int i = 0; i < N_CH; i++) if (c[i]) m_ctx[i] = 0;
    e.ch = 2'(m_hch);
    e.st = model_pack();
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      chk("hit_valid", 32'(hit_valid), 32'(got.hv));
      chk("hit_ch", 32'(hit_ch), 32'(got.ch));
      chk("ch_state", 32'(ch_state), 32'(got.st));
    end
  endtask

  initial begin
    logic [3:0] rv;
    logic [3:0] rd;
    logic [3:0] rc;
    bit_valid = '0;
    bit_data  = '0;
    ch_clear  = '0;
    rst_n     = 1'b0;
    model_reset();
    #2;
    chk("rst_hit_valid", 32'(hit_valid), 32'd0);
    chk("rst_hit_ch", 32'(hit_ch), 32'd0);
    chk("rst_ch_state", 32'(ch_state), 32'd0);
    chk("rst_bit_ready", 32'(bit_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) cycle(4'b0000, 4'b0000, 4'b0000);

    // Channel 1 alone: 1,1,1,0,1,1 -> hits on the 2nd and 6th bits
    cycle(4'b0010, 4'b0010, 4'b0000);
    cycle(4'b0010, 4'b0010, 4'b0000);
    cycle(4'b0010, 4'b0010, 4'b0000);
    cycle(4'b0010, 4'b0000, 4'b0000);
    cycle(4'b0010, 4'b0010, 4'b0000);
    cycle(4'b0010, 4'b0010, 4'b0000);
    chk("ch1_final_state", 32'(ch_state[3:2]), 32'd2);

    // Bring pointer to 0, clear everything, then full load of ones
    cycle(4'b1000, 4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0000, 4'b1111);
    repeat (8) cycle(4'b1111, 4'b1111, 4'b0000);

    // Channel 2 clear while its bit is pending
    cycle(4'b0000, 4'b0000, 4'b1111);
    cycle(4'b0100, 4'b0100, 4'b0000);
    cycle(4'b0100, 4'b0100, 4'b0100);
    cycle(4'b0100, 4'b0100, 4'b0000);
    chk("ch2_after_clear", 32'(ch_state[5:4]), 32'd1);

    // Pointer at 3 with channels 0 and 3 requesting: 3 then 0
    cycle(4'b1001, 4'b0000, 4'b0000);
    cycle(4'b1001, 4'b0000, 4'b0000);

    // Random traffic with occasional clears
    repeat (40) begin
      rv = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      rc = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cycle(rv, rd, rc);
    end

    // Asynchronous reset while a hit is being reported
    cycle(4'b0000, 4'b0000, 4'b1111);
    cycle(4'b0001, 4'b0001, 4'b0000);
    cycle(4'b0001, 4'b0001, 4'b0000);
    bit_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hit_valid", 32'(hit_valid), 32'd0);
    chk("async_rst_ch_state", 32'(ch_state), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(4'b0001, 4'b0001, 4'b0000);
    cycle(4'b0001, 4'b0001, 4'b0000);
    cycle(4'b0000, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
